// File: rtl/uart_rx_cfg_if.sv
`timescale 1ns/1ps
// Configuration, serial line and received-word signals of the configurable UART receiver.
interface uart_rx_cfg_if #(
  parameter int DIV_W = 16
) ();
  logic [DIV_W-1:0] baud_div;
  logic [1:0]       data_bits;
  logic [1:0]       parity_mode;
  logic             stop_bits;
  logic             Rs232_Rx;
  logic [7:0]       data_byte;
  logic             Rx_Done;
  logic             parity_err;
  logic             frame_err;
  logic             busy;

  modport master (
    output baud_div, data_bits, parity_mode, stop_bits, Rs232_Rx,
    input  data_byte, Rx_Done, parity_err, frame_err, busy
  );

  modport slave (
    input  baud_div, data_bits, parity_mode, stop_bits, Rs232_Rx,
    output data_byte, Rx_Done, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
// Configurable UART receiver: 16x oversampling with 6-sample majority vote,
// 5-8 data bits, none/even/odd parity, 1 or 2 stop bits, programmable divisor.
module uart_rx_cfg #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic         Clk,
  input  logic         Rst_n,
  uart_rx_cfg_if.slave bus
);

  localparam logic [3:0] PH_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] PH_WIN_LO = 4'd6;
  localparam logic [3:0] PH_WIN_HI = 4'd11;
  localparam logic [3:0] PH_DECIDE = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  function automatic logic parity_bad(input logic [7:0] word, input logic par_bit,
                                      input logic odd);
    return (((^word) ^ par_bit) != odd);
  endfunction

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, dly1_q, dly2_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       ph_q, ph_d;
  logic [2:0]       acc_q, acc_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             stop_idx_q, stop_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             perr_pend_q, perr_pend_d;
  logic             ferr_pend_q, ferr_pend_d;
  logic [DIV_W-1:0] baud_div_q, baud_div_d;
  logic [1:0]       data_bits_q, data_bits_d;
  logic [1:0]       parity_mode_q, parity_mode_d;
  logic             stop_bits_q, stop_bits_d;
  logic [7:0]       data_byte_q, data_byte_d;
  logic             rx_done_q, rx_done_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q;

  logic fall_s, tick_s, in_win_s, mid_s, wrap_s, vote_s, par_en_s;

  // Falling edge is taken from the delayed pair so metastability never reaches it.
  assign fall_s   = dly2_q & ~dly1_q;
  assign tick_s   = (state_q != S_IDLE) && (div_cnt_q == baud_div_q);
  assign in_win_s = (ph_q >= PH_WIN_LO) && (ph_q <= PH_WIN_HI);
  assign mid_s    = tick_s && (ph_q == PH_DECIDE);
  assign wrap_s   = tick_s && (ph_q == PH_LAST);
  assign vote_s   = (acc_q >= 3'd4);
  assign par_en_s = (parity_mode_q == 2'd1) || (parity_mode_q == 2'd2);

  // Line synchroniser and edge-detect delay chain.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      dly1_q  <= 1'b1;
      dly2_q  <= 1'b1;
    end else begin
      sync1_q <= bus.Rs232_Rx;
      sync2_q <= sync1_q;
      dly1_q  <= sync2_q;
      dly2_q  <= dly1_q;
    end
  end

  // Frame state, counters, latched configuration and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= S_IDLE;
      div_cnt_q     <= {DIV_W{1'b0}};
      ph_q          <= 4'd0;
      acc_q         <= 3'd0;
      bit_idx_q     <= 3'd0;
      stop_idx_q    <= 1'b0;
      shift_q       <= 8'd0;
      perr_pend_q   <= 1'b0;
      ferr_pend_q   <= 1'b0;
      baud_div_q    <= {DIV_W{1'b0}};
      data_bits_q   <= 2'd0;
      parity_mode_q <= 2'd0;
      stop_bits_q   <= 1'b0;
      data_byte_q   <= 8'd0;
      rx_done_q     <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      ph_q          <= ph_d;
      acc_q         <= acc_d;
      bit_idx_q     <= bit_idx_d;
      stop_idx_q    <= stop_idx_d;
      shift_q       <= shift_d;
      perr_pend_q   <= perr_pend_d;
      ferr_pend_q   <= ferr_pend_d;
      baud_div_q    <= baud_div_d;
      data_bits_q   <= data_bits_d;
      parity_mode_q <= parity_mode_d;
      stop_bits_q   <= stop_bits_d;
      data_byte_q   <= data_byte_d;
      rx_done_q     <= rx_done_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= (state_d != S_IDLE);
    end
  end

  // Tick/phase/vote datapath and next-state decode.
  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    ph_d          = ph_q;
    acc_d         = acc_q;
    bit_idx_d     = bit_idx_q;
    stop_idx_d    = stop_idx_q;
    shift_d       = shift_q;
    perr_pend_d   = perr_pend_q;
    ferr_pend_d   = ferr_pend_q;
    baud_div_d    = baud_div_q;
    data_bits_d   = data_bits_q;
    parity_mode_d = parity_mode_q;
    stop_bits_d   = stop_bits_q;
    data_byte_d   = data_byte_q;
    parity_err_d  = parity_err_q;
    frame_err_d   = frame_err_q;
    rx_done_d     = 1'b0;

    if (tick_s) begin
      div_cnt_d = {DIV_W{1'b0}};
      ph_d      = (ph_q == PH_LAST) ? 4'd0 : (ph_q + 4'd1);
      if (in_win_s) begin
        acc_d = acc_q + {2'b00, sync2_q};
      end else if (ph_q == PH_DECIDE) begin
        acc_d = 3'd0;
      end else begin
        acc_d = acc_q;
      end
    end else if (state_q != S_IDLE) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end else begin
      div_cnt_d = {DIV_W{1'b0}};
    end

    case (state_q)
      S_IDLE: begin
        div_cnt_d  = {DIV_W{1'b0}};
        ph_d       = 4'd0;
        acc_d      = 3'd0;
        bit_idx_d  = 3'd0;
        stop_idx_d = 1'b0;
        if (fall_s) begin
          state_d       = S_START;
          baud_div_d    = bus.baud_div;
          data_bits_d   = bus.data_bits;
          parity_mode_d = bus.parity_mode;
          stop_bits_d   = bus.stop_bits;
          shift_d       = 8'd0;
          perr_pend_d   = 1'b0;
          ferr_pend_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        // A start bit that votes mostly high is treated as a glitch.
        if (mid_s && (acc_q >= 3'd3)) begin
          state_d = S_IDLE;
        end else if (wrap_s) begin
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (mid_s) begin
          shift_d[bit_idx_q] = vote_s;
        end else if (wrap_s) begin
          if (bit_idx_q == ({1'b0, data_bits_q} + 3'd4)) begin
            bit_idx_d = 3'd0;
            state_d   = par_en_s ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (mid_s) begin
          perr_pend_d = parity_bad(shift_q, vote_s, parity_mode_q == 2'd2);
        end else if (wrap_s) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        // The final stop bit is decided at its centre so back-to-back frames resync.
        if (mid_s) begin
          if (stop_idx_q == stop_bits_q) begin
            data_byte_d  = shift_q;
            parity_err_d = perr_pend_q;
            frame_err_d  = ferr_pend_q | ~vote_s;
            rx_done_d    = 1'b1;
            state_d      = S_IDLE;
          end else begin
            ferr_pend_d = ferr_pend_q | ~vote_s;
          end
        end else if (wrap_s) begin
          stop_idx_d = 1'b1;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.data_byte  = data_byte_q;
  assign bus.Rx_Done    = rx_done_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
// Bench for uart_rx_cfg: a line driver serialises frames, a reference model
// predicts each word into a scoreboard, and a monitor scores every Rx_Done.
module tb_uart_rx_cfg;
  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   waited;
  exp_t sb_q[$];

  always #5 Clk = ~Clk;

  uart_rx_cfg_if #(.DIV_W(16)) bus ();

  uart_rx_cfg #(.OVERSAMPLE(16), .DIV_W(16)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected word straight from the frame rules: mask to N bits, count ones.
  function automatic exp_t model(input logic [7:0] d, input int n, input int pm, input int s,
                                 input logic p_sent, input logic [1:0] stops);
    exp_t e;
    int   ones;
    e.data = 8'(int'(d) & ((1 << n) - 1));
    ones   = $countones(e.data);
    e.perr = ((pm == 1) && (int'(p_sent) != (ones % 2))) ||
             ((pm == 2) && (int'(p_sent) != (1 - (ones % 2))));
    e.ferr = !stops[0] || ((s == 2) && !stops[1]);
    return e;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input int cyc);
    bus.Rs232_Rx = v;
    if (cyc > 0) wait_cyc(cyc);
  endtask

  task automatic set_cfg(input int n, input int pm, input int s, input int div);
    bus.baud_div    = 16'(div);
    bus.data_bits   = 2'(n - 5);
    bus.parity_mode = 2'(pm);
    bus.stop_bits   = 1'(s - 1);
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input int pm, input int s,
                            input logic p_sent, input logic [1:0] stops, input int div,
                            input int pct, input int gap_bits, input bit noise);
    int bitcyc;
    int tk;
    tk     = div + 1;
    bitcyc = (16 * tk * pct) / 100;
    set_cfg(n, pm, s, div);
    sb_q.push_back(model(d, n, pm, s, p_sent, stops));
    drive(1'b0, bitcyc);
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        drive(d[i], 8 * tk);
        drive(~d[i], tk);
        drive(d[i], bitcyc - 9 * tk);
      end else begin
        drive(d[i], bitcyc);
      end
    end
    if ((pm == 1) || (pm == 2)) drive(p_sent, bitcyc);
    drive(stops[0], bitcyc);
    if (s == 2) drive(stops[1], bitcyc);
    drive(1'b1, gap_bits * bitcyc);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data_byte"}, int'(bus.data_byte), 0);
    check({tag, "_rx_done"}, int'(bus.Rx_Done), 0);
    check({tag, "_parity_err"}, int'(bus.parity_err), 0);
    check({tag, "_frame_err"}, int'(bus.frame_err), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  // Monitor: scores each Rx_Done against the oldest prediction.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge Clk);
      if (Rst_n && bus.Rx_Done) begin
        check("rx_done_single_cycle", int'(prev_done), 0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rx_done: data_byte 0x%0h with nothing expected at %0t",
                   bus.data_byte, $time);
        end else begin
          e = sb_q.pop_front();
          check("data_byte", int'(bus.data_byte), int'(e.data));
          check("parity_err", int'(bus.parity_err), int'(e.perr));
          check("frame_err", int'(bus.frame_err), int'(e.ferr));
        end
      end
      prev_done = bus.Rx_Done;
    end
  end

  initial begin
    bus.Rs232_Rx = 1'b1;
    set_cfg(8, 0, 1, 26);
    Rst_n = 1'b0;
    wait_cyc(5);
    check_idle_outputs("reset");
    Rst_n = 1'b1;
    wait_cyc(20);

    // 8N1 back-to-back at 115200-equivalent divisor
    send_frame(8'hA5, 8, 0, 1, 1'b0, 2'b11, 26, 100, 0, 1'b0);
    send_frame(8'h3C, 8, 0, 1, 1'b0, 2'b11, 26, 100, 2, 1'b0);
    // 7E1 with correct and with wrong parity bit
    send_frame(8'h41, 7, 1, 1, 1'b0, 2'b11, 7, 100, 2, 1'b0);
    send_frame(8'h41, 7, 1, 1, 1'b1, 2'b11, 7, 100, 2, 1'b0);
    // 5O2 with the second stop bit low
    send_frame(8'h15, 5, 2, 2, 1'b0, 2'b01, 7, 100, 2, 1'b0);

    // Start-bit glitch of three tick periods
    set_cfg(8, 0, 1, 26);
    drive(1'b0, 81);
    drive(1'b1, 0);
    check("glitch_busy_rise", int'(bus.busy), 1);
    waited = 0;
    while (bus.busy && (waited < 1000)) begin
      wait_cyc(1);
      waited++;
    end
    check("glitch_busy_fall", int'(bus.busy), 0);
    wait_cyc(2 * 432);
    send_frame(8'h55, 8, 0, 1, 1'b0, 2'b11, 26, 100, 2, 1'b0);

    // Reset in the middle of data bit 4
    set_cfg(8, 0, 1, 7);
    drive(1'b0, 128);
    for (int i = 0; i < 4; i++) drive(1'(8'h96 >> i), 128);
    drive(1'b0, 64);
    Rst_n = 1'b0;
    bus.Rs232_Rx = 1'b1;
    wait_cyc(3);
    check_idle_outputs("midframe_reset");
    Rst_n = 1'b1;
    wait_cyc(3 * 128);
    send_frame(8'hC3, 8, 0, 1, 1'b0, 2'b11, 7, 100, 2, 1'b0);

    // One-tick inversion in the middle of every data bit
    send_frame(8'h00, 8, 0, 1, 1'b0, 2'b11, 7, 100, 2, 1'b1);

    // data_bits changed mid-frame must not affect the current word
    fork
      send_frame(8'hB7, 8, 0, 1, 1'b0, 2'b11, 7, 100, 2, 1'b0);
      begin
        wait_cyc(3 * 128);
        bus.data_bits = 2'd0;
      end
    join

    // Break: line held low well past a full frame
    set_cfg(8, 0, 1, 7);
    sb_q.push_back(model(8'h00, 8, 0, 1, 1'b0, 2'b00));
    drive(1'b0, 12 * 128);
    drive(1'b1, 3 * 128);

    // +/-3 % baud mismatch on 8-bit frames
    send_frame(8'hD2, 8, 0, 1, 1'b0, 2'b11, 26, 103, 2, 1'b0);
    send_frame(8'h2D, 8, 0, 1, 1'b0, 2'b11, 26, 97, 2, 1'b0);

    // Divisor 0: one tick per clock
    send_frame(8'h6A, 8, 2, 1, 1'b1, 2'b11, 0, 100, 2, 1'b0);

    // Randomised formats, data, parity bits and stop bits
    for (int f = 0; f < 16; f++) begin
      int         n, pm, s, div, gap;
      logic [7:0] d;
      logic       p;
      logic [1:0] st;
      n   = 5 + int'($urandom_range(3));
      pm  = int'($urandom_range(3));
      s   = 1 + int'($urandom_range(1));
      div = 2 + int'($urandom_range(4));
      d   = 8'($urandom);
      p   = 1'($urandom);
      st  = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b11;
      gap = int'($urandom_range(2));
      if (!st[s-1]) gap = gap + 1;
      send_frame(d, n, pm, s, p, st, div, 100, gap, 1'b0);
    end

    waited = 0;
    while ((sb_q.size() != 0) && (waited < 5000)) begin
      wait_cyc(1);
      waited++;
    end
    check("scoreboard_drained", sb_q.size(), 0);
    wait_cyc(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Configurable UART receiver for the sensor data path: the next generation of the fixed 8N1 byte receiver. It adds runtime-selectable frame format (5–8 data bits, none/even/odd parity, 1 or 2 stop bits) and a programmable baud divisor. It keeps 16× oversampling with 6-sample majority voting and start-bit glitch rejection, and reports parity and framing errors alongside each received word.

## Interface
- `OVERSAMPLE`, default 16: ticks per bit. Fixed at 16 in this revision; sample window is ticks 6..11.
- `DIV_W`, default 16: width of the baud divisor.
- `Clk` in 1: system clock (50 MHz nominal).
- `Rst_n` in 1: asynchronous, active-low reset.
- `baud_div` in DIV_W: oversample tick period minus 1, in Clk cycles. 26 gives 115200 baud at 50 MHz.
- `data_bits` in 2: 0 = 5 bits, 1 = 6, 2 = 7, 3 = 8.
- `parity_mode` in 2: 0 = none, 1 = even, 2 = odd, 3 = none.
- `stop_bits` in 1: 0 = one stop bit, 1 = two.
- `Rs232_Rx` in 1: serial input, asynchronous to Clk.
- `data_byte` out 8: received word, LSB first on the line, right-justified, unused upper bits 0.
- `Rx_Done` out 1: one-cycle pulse marking that `data_byte` and the error flags are valid.
- `parity_err` out 1: parity mismatch for the word flagged by `Rx_Done`.
- `frame_err` out 1: at least one stop bit sampled as 0.
- `busy` out 1: high while a frame is in progress (state != IDLE).

## Operation
- Input conditioning:
  - 2-flop synchroniser on `Rs232_Rx`, then 2 more delay flops.
  - A falling edge is flagged when the delayed pair is 1→0.
  - Majority sampling uses the synchroniser output.
- Config latching: `baud_div`, `data_bits`, `parity_mode` and `stop_bits` are latched on the edge that leaves IDLE. Changes mid-frame have no effect until the next frame.
- Tick generator:
  - `div_cnt` counts 0..baud_div_l while not IDLE and is held at 0 in IDLE.
  - A tick pulses in the cycle when `div_cnt == baud_div_l`.
- Phase counter `ph` (0..15):
  - Increments on each tick and wraps at 15.
  - On each wrap, the bit index advances and the state moves on.
- Majority vote:
  - On ticks where `ph` is 6..11, the 3-bit accumulator adds the synchronised line value.
  - At the tick with `ph == 12`, the bit value is accumulator ≥ 4, and the accumulator clears.
- States:
  - IDLE: falling edge → START; all counters cleared.
  - START: at `ph == 12`, if accumulator ≥ 3 (glitch or noise), return to IDLE with no `Rx_Done` and no flags. Otherwise, at the wrap → DATA.
  - DATA: bits shift in LSB first into shift register bit index k. After bit `data_bits_l + 4` wraps → PARITY if parity is enabled, else STOP.
  - PARITY:
    - Received parity bit is compared against the XOR of the data bits.
    - Even mode requires XOR(data, p) = 0; odd mode requires 1.
    - At the wrap → STOP.
  - STOP:
    - Each stop bit is voted; any 0 sets the `frame_err` pending flag.
    - On the final stop bit at `ph == 12`: register outputs, pulse `Rx_Done` next cycle, go to IDLE. The remainder of the stop bit is not waited out, so back-to-back frames resync.
- Output register:
  - `data_byte`, `parity_err` and `frame_err` load simultaneously in the cycle `Rx_Done` is high.
  - They hold until the next `Rx_Done`.
  - `parity_err` is 0 when parity is disabled.
- Falling edges while not IDLE are ignored.
- A break condition (line held low) yields one word with `frame_err = 1`. No further frame starts until the line returns high and falls again.

## Timing
- Reset values: `data_byte` = 0, `Rx_Done` = 0, `parity_err` = 0, `frame_err` = 0, `busy` = 0. State is IDLE and all counters are 0.
- Reset mid-frame aborts immediately, with no `Rx_Done`.
- Edge-detect latency: 3 Clk cycles from a line transition to the IDLE→START transition.
- Frame length in ticks: 16 × (1 + N + P) + 16 × (S − 1) + 13. N is the data-bit count, P is 1 if parity is enabled, S is the stop-bit count.
- `Rx_Done` is high for exactly 1 Clk cycle, even if `baud_div` = 0 (one tick per cycle).
- `baud_div` = 0 is legal; the tick fires every cycle.
- Tolerance: ±3 % baud mismatch must still decode correctly for 8-bit frames.

## Test plan
- 8N1, `baud_div` = 26, send 0xA5 then 0x3C back-to-back with a single stop bit → two `Rx_Done` pulses, `data_byte` = 0xA5 then 0x3C, both errors 0.
- 7E1, send 0x41 with correct parity bit 0 → `data_byte` = 0x41, `parity_err` = 0. Repeat with the parity bit forced to 1 → `parity_err` = 1, data still 0x41.
- 5O2, send 0x15 with the second stop bit driven 0 → `data_byte` = 0x15, `frame_err` = 1, `parity_err` = 0.
- Glitch rejection: line pulsed low for 3 tick periods (about 81 Clk cycles) → `busy` rises then falls by `ph` 12 of START, no `Rx_Done`. A valid 0x55 following 2 bit-times later decodes correctly.
- Single-sample noise: line inverted for 1 tick in the middle of each data bit of 0x00 → `data_byte` = 0x00 via majority vote.
- Reset and config change:
  - Assert `Rst_n` low at data bit 4 of a frame → all outputs 0 and no `Rx_Done`. The next frame, 0xC3, decodes.
  - Change `data_bits` from 3 to 0 mid-frame → the current frame still decodes as 8 bits.
